// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial-sequence family (pattern transmitter and
// the sequence detectors that consume its stream).
//   state_t      : FSM state encoding common to the family
//   DEF_PAT_W    : default pattern length in bits
//   DEF_PATTERN  : default pattern value, sent MSB first
//   min1_clog2() : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  localparam int DEF_PAT_W = 3;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b101;

  // A counter that only ever holds 0 still needs one bit of storage.
  function automatic int min1_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx_if
// Request/stream bundle of the serial pattern transmitter.
//   start    : request, sampled only while the transmitter is idle
//   repeat_n : number of frames to send, CNT_W bits
//   abort    : synchronous cancel
//   out      : serial data bit
//   valid    : out carries a pattern bit this cycle
//   busy     : transmitter is sending or waiting between frames
//   done     : one-cycle pulse after the last bit of the last frame
// Modports: master drives the request side, slave is the transmitter.
// ---------------------------------------------------------------------------
interface seq_pattern_tx_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic [CNT_W-1:0] repeat_n;
  logic             abort;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, repeat_n, abort,
    input  out, valid, busy, done
  );

  modport slave (
    input  start, repeat_n, abort,
    output out, valid, busy, done
  );

endinterface

// File: rtl/seq_pat_shifter.sv
// ---------------------------------------------------------------------------
// seq_pat_shifter
// Loadable PAT_W-bit shift register presenting its MSB as the serial bit.
//   clk   : clock, posedge
//   rst   : asynchronous active-high reset, clears the register
//   load  : load PATTERN
//   shift : shift left by one, zero filled
//   clear : clear to zero (priority clear > load > shift)
//   msb   : current MSB, a flop output
// ---------------------------------------------------------------------------
module seq_pat_shifter #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic clear,
  output logic msb
);

  logic [PAT_W-1:0] sh;
  logic [PAT_W-1:0] sh_shifted;

  // A one-bit pattern has nothing to shift in behind the MSB.
  generate
    if (PAT_W == 1) begin : g_single
      assign sh_shifted = '0;
    end else begin : g_multi
      assign sh_shifted = {sh[PAT_W-2:0], 1'b0};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
    end else if (clear) begin
      sh <= '0;
    end else if (load) begin
      sh <= PATTERN;
    end else if (shift) begin
      sh <= sh_shifted;
    end
  end

  assign msb = sh[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Serial pattern transmitter. On an accepted start it sends PATTERN MSB
// first, one bit per clock, repeat_n times, with GAP idle cycles between
// frames, then pulses done for one cycle.
//   clk : clock, posedge
//   rst : asynchronous active-high reset
//   bus : seq_pattern_tx_if.slave
//         start/repeat_n/abort in; out/valid/busy/done out (all registered)
// Parameters: PAT_W, PATTERN, CNT_W (must match the interface), GAP.
// ---------------------------------------------------------------------------
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 4,
  parameter int               GAP     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_pattern_tx_if.slave      bus
);

  localparam int BIT_W = min1_clog2(PAT_W);
  localparam int GAP_W = min1_clog2(GAP + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  state_t           state;
  state_t           state_n;
  logic [BIT_W-1:0] bit_idx;
  logic [BIT_W-1:0] bit_idx_n;
  logic [CNT_W-1:0] frames_left;
  logic [CNT_W-1:0] frames_n;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_n;

  logic sh_load;
  logic sh_shift;
  logic sh_clear;
  logic sh_msb;

  logic valid_q;
  logic busy_q;
  logic done_q;

  // The shifter holds the frame in flight; its MSB flop is the serial output.
  // It is cleared whenever the FSM leaves SEND, which keeps out low while
  // valid is low.
  seq_pat_shifter #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .clear (sh_clear),
    .msb   (sh_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_idx     <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_n;
      bit_idx     <= bit_idx_n;
      frames_left <= frames_n;
      gap_cnt     <= gap_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    frames_n  = frames_left;
    gap_n     = gap_cnt;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_clear  = 1'b0;

    if (bus.abort) begin
      // abort also swallows a start presented in the same idle cycle
      state_n   = ST_IDLE;
      bit_idx_n = '0;
      frames_n  = '0;
      gap_n     = '0;
      sh_clear  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && (bus.repeat_n != '0)) begin
            state_n   = ST_SEND;
            frames_n  = bus.repeat_n;
            bit_idx_n = BIT_LAST;
            sh_load   = 1'b1;
          end
        end

        ST_SEND: begin
          if (bit_idx == '0) begin
            if (frames_left == CNT_W'(1)) begin
              state_n  = ST_DONE;
              frames_n = '0;
              sh_clear = 1'b1;
            end else begin
              frames_n = frames_left - 1'b1;
              if (GAP > 0) begin
                state_n  = ST_GAP;
                gap_n    = GAP_LOAD;
                sh_clear = 1'b1;
              end else begin
                bit_idx_n = BIT_LAST;
                sh_load   = 1'b1;
              end
            end
          end else begin
            bit_idx_n = bit_idx - 1'b1;
            sh_shift  = 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state_n   = ST_SEND;
            gap_n     = '0;
            bit_idx_n = BIT_LAST;
            sh_load   = 1'b1;
          end else begin
            gap_n = gap_cnt - 1'b1;
          end
        end

        ST_DONE: begin
          state_n = ST_IDLE;
        end

        default: begin
          state_n  = ST_IDLE;
          sh_clear = 1'b1;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with
  // the shifter MSB that becomes visible after the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= (state_n == ST_SEND);
      busy_q  <= (state_n == ST_SEND) || (state_n == ST_GAP);
      done_q  <= (state_n == ST_DONE);
    end
  end

  assign bus.out   = sh_msb;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
// Directed bench for seq_pattern_tx. Two instances share the same stimulus:
// dut_g1 with GAP=1 and dut_g0 with GAP=0 (back-to-back frames).
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic clk;
  logic rst;

  int check_cnt;
  int pass_cnt;

  logic [2:0] det_hist;
  int         det_bits;
  int         det_hits;

  seq_pattern_tx_if #(.CNT_W(4)) bus_g1 ();
  seq_pattern_tx_if #(.CNT_W(4)) bus_g0 ();

  seq_pattern_tx #(
    .PAT_W   (3),
    .PATTERN (3'b101),
    .CNT_W   (4),
    .GAP     (1)
  ) dut_g1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_g1)
  );

  seq_pattern_tx #(
    .PAT_W   (3),
    .PATTERN (3'b101),
    .CNT_W   (4),
    .GAP     (0)
  ) dut_g0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [3:0] rn,
                               input logic ab);
    bus_g1.start    = st;
    bus_g1.repeat_n = rn;
    bus_g1.abort    = ab;
    bus_g0.start    = st;
    bus_g0.repeat_n = rn;
    bus_g0.abort    = ab;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectCycle(input string tag, input logic e_out,
                             input logic e_valid, input logic e_busy,
                             input logic e_done);
    stepCycle();
    checkOutput({tag, ".out"},   32'(bus_g1.out),   32'(e_out));
    checkOutput({tag, ".valid"}, 32'(bus_g1.valid), 32'(e_valid));
    checkOutput({tag, ".busy"},  32'(bus_g1.busy),  32'(e_busy));
    checkOutput({tag, ".done"},  32'(bus_g1.done),  32'(e_done));
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    rst       = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.out",   32'(bus_g1.out),   32'd0);
    checkOutput("rst.valid", 32'(bus_g1.valid), 32'd0);
    checkOutput("rst.busy",  32'(bus_g1.busy),  32'd0);
    checkOutput("rst.done",  32'(bus_g1.done),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single frame: 1,0,1 then done
    applyStimulus(1'b1, 4'd1, 1'b0);
    expectCycle("t1.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t1.c2", 1'b0, 1'b1, 1'b1, 1'b0);
    expectCycle("t1.c3", 1'b1, 1'b1, 1'b1, 1'b0);
    expectCycle("t1.c4", 1'b0, 1'b0, 1'b0, 1'b1);
    expectCycle("t1.c5", 1'b0, 1'b0, 1'b0, 1'b0);

    // two frames with a one-cycle gap
    applyStimulus(1'b1, 4'd2, 1'b0);
    expectCycle("t2.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t2.c2", 1'b0, 1'b1, 1'b1, 1'b0);
    expectCycle("t2.c3", 1'b1, 1'b1, 1'b1, 1'b0);
    expectCycle("t2.c4", 1'b0, 1'b0, 1'b1, 1'b0);
    expectCycle("t2.c5", 1'b1, 1'b1, 1'b1, 1'b0);
    expectCycle("t2.c6", 1'b0, 1'b1, 1'b1, 1'b0);
    expectCycle("t2.c7", 1'b1, 1'b1, 1'b1, 1'b0);
    expectCycle("t2.c8", 1'b0, 1'b0, 1'b0, 1'b1);
    expectCycle("t2.c9", 1'b0, 1'b0, 1'b0, 1'b0);

    // three frames: back-to-back on dut_g0 into a 101 detector model,
    // dut_g1 finishes later because of its gaps (3*3 + 2*1 + 1 = 12)
    stepCycle();
    applyStimulus(1'b1, 4'd3, 1'b0);
    det_hist = '0;
    det_bits = 0;
    det_hits = 0;
    for (int c = 1; c <= 12; c++) begin
      stepCycle();
      if (bus_g0.valid === 1'b1) begin
        det_hist = {det_hist[1:0], bus_g0.out};
        det_bits++;
        if ((det_bits >= 3) && (det_hist == 3'b101)) det_hits++;
      end
      if (c <= 9) begin
        checkOutput($sformatf("t3.g0.out%0d", c), 32'(bus_g0.out),
                    ((c - 1) % 3 == 1) ? 32'd0 : 32'd1);
        checkOutput($sformatf("t3.g0.valid%0d", c), 32'(bus_g0.valid), 32'd1);
      end else begin
        checkOutput($sformatf("t3.g0.valid%0d", c), 32'(bus_g0.valid), 32'd0);
        checkOutput($sformatf("t3.g0.done%0d", c), 32'(bus_g0.done),
                    (c == 10) ? 32'd1 : 32'd0);
      end
      checkOutput($sformatf("t3.g1.done%0d", c), 32'(bus_g1.done),
                  (c == 12) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t3.g1.busy%0d", c), 32'(bus_g1.busy),
                  (c < 12) ? 32'd1 : 32'd0);
      if (c == 1) applyStimulus(1'b0, 4'd0, 1'b0);
    end
    checkOutput("t3.det_hits", 32'(det_hits), 32'd3);

    // repeat_n == 0 is ignored
    applyStimulus(1'b1, 4'd0, 1'b0);
    expectCycle("t4.c1", 1'b0, 1'b0, 1'b0, 1'b0);
    expectCycle("t4.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t4.c3", 1'b0, 1'b0, 1'b0, 1'b0);

    // start held high through SEND and DONE, repeat_n changed after accept
    applyStimulus(1'b1, 4'd1, 1'b0);
    expectCycle("t5.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b0);
    expectCycle("t5.c2", 1'b0, 1'b1, 1'b1, 1'b0);
    expectCycle("t5.c3", 1'b1, 1'b1, 1'b1, 1'b0);
    expectCycle("t5.c4", 1'b0, 1'b0, 1'b0, 1'b1);
    expectCycle("t5.c5", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t5.c6", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort during cycle 2 of frame 1
    applyStimulus(1'b1, 4'd2, 1'b0);
    expectCycle("t6.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t6.c2", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1);
    expectCycle("t6.c3", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t6.c4", 1'b0, 1'b0, 1'b0, 1'b0);
    expectCycle("t6.c5", 1'b0, 1'b0, 1'b0, 1'b0);

    // abort and start together in idle: start dropped
    applyStimulus(1'b1, 4'd1, 1'b1);
    expectCycle("t7.c1", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t7.c2", 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-frame drops outputs without a clock edge
    applyStimulus(1'b1, 4'd3, 1'b0);
    expectCycle("t8.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t8.c2", 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t8.rst.out",   32'(bus_g1.out),   32'd0);
    checkOutput("t8.rst.valid", 32'(bus_g1.valid), 32'd0);
    checkOutput("t8.rst.busy",  32'(bus_g1.busy),  32'd0);
    checkOutput("t8.rst.done",  32'(bus_g1.done),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // fresh run after reset release
    applyStimulus(1'b1, 4'd1, 1'b0);
    expectCycle("t9.c1", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    expectCycle("t9.c2", 1'b0, 1'b1, 1'b1, 1'b0);
    expectCycle("t9.c3", 1'b1, 1'b1, 1'b1, 1'b0);
    expectCycle("t9.c4", 1'b0, 1'b0, 1'b0, 1'b1);
    expectCycle("t9.c5", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
